// File: rtl/cursor_spi_tx.sv
// SPI mode-0 master that sends {xcursor, ycursor} as one MSB-first frame.
// Define CURSOR_SPI_CS_EN to drive an active-low frame select on cs_b.
module cursor_spi_tx #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned WORD_W  = 16
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              start,
   input  logic [WORD_W-1:0] xcursor,
   input  logic [WORD_W-1:0] ycursor,
   output logic              sclk,
   output logic              sdo,
   output logic              cs_b,
   output logic              busy,
   output logic              done
);

   localparam int unsigned FRAME_W = 2 * WORD_W;
   localparam int unsigned CNT_W   = $clog2(CLK_DIV) + 1;
   localparam int unsigned BIT_W   = $clog2(FRAME_W) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SHIFT_HI,
      S_SHIFT_LO,
      S_TRAIL
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
   logic [FRAME_W-1:0] r_shift, w_shift_nxt;
   logic               r_sclk, w_sclk_nxt;
   logic               r_sdo, w_sdo_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_cs_b, w_cs_b_nxt;
   logic               w_half_end;

   assign w_half_end = (r_cnt == CNT_W'(CLK_DIV - 1));

   // Next-state and next-output logic; every phase lasts exactly one half-period.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = w_half_end ? '0 : r_cnt + CNT_W'(1);
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_sclk_nxt    = r_sclk;
      w_sdo_nxt     = r_sdo;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_cs_b_nxt    = r_cs_b;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (start && !r_busy) begin
               w_state_nxt   = S_LEAD;
               w_shift_nxt   = {xcursor, ycursor};
               w_bit_cnt_nxt = '0;
               w_sdo_nxt     = xcursor[WORD_W-1];
               w_sclk_nxt    = 1'b0;
               w_busy_nxt    = 1'b1;
               w_cs_b_nxt    = 1'b0;
            end
         end
         S_LEAD: begin
            if (w_half_end) begin
               w_state_nxt = S_SHIFT_HI;
               w_sclk_nxt  = 1'b1;
            end
         end
         S_SHIFT_HI: begin
            if (w_half_end) begin
               w_state_nxt   = S_SHIFT_LO;
               w_sclk_nxt    = 1'b0;
               w_shift_nxt   = {r_shift[FRAME_W-2:0], 1'b0};
               w_sdo_nxt     = r_shift[FRAME_W-2];
               w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            end
         end
         S_SHIFT_LO: begin
            if (w_half_end) begin
               if (r_bit_cnt == BIT_W'(FRAME_W)) begin
                  w_state_nxt = S_TRAIL;
                  w_sdo_nxt   = 1'b0;
               end else begin
                  w_state_nxt = S_SHIFT_HI;
                  w_sclk_nxt  = 1'b1;
               end
            end
         end
         S_TRAIL: begin
            if (w_half_end) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_cs_b_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_sclk_nxt  = 1'b0;
            w_sdo_nxt   = 1'b0;
            w_cs_b_nxt  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_sclk    <= 1'b0;
         r_sdo     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_sclk    <= w_sclk_nxt;
         r_sdo     <= w_sdo_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

`ifdef CURSOR_SPI_CS_EN
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) r_cs_b <= 1'b1;
      else          r_cs_b <= w_cs_b_nxt;
   end
   assign cs_b = r_cs_b;
`else
   // Receiver frames on the clock count alone, so select is held inactive.
   assign r_cs_b = 1'b1;
   assign cs_b   = 1'b1;
`endif

   assign sclk = r_sclk;
   assign sdo  = r_sdo;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_cursor_spi_tx.sv
// Bench for cursor_spi_tx: two instances (CLK_DIV 4 and 1) checked against frame-level timing rules.
module tb_cursor_spi_tx;

   logic        clk = 1'b0;
   logic        reset_b;
   logic [1:0]  start;
   logic [15:0] xc [2];
   logic [15:0] yc [2];
   logic [1:0]  sclk, sdo, cs_b, busy, done;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   cursor_spi_tx #(.CLK_DIV(4), .WORD_W(16)) u_div4 (
      .clk(clk), .reset_b(reset_b), .start(start[0]), .xcursor(xc[0]), .ycursor(yc[0]),
      .sclk(sclk[0]), .sdo(sdo[0]), .cs_b(cs_b[0]), .busy(busy[0]), .done(done[0]));

   cursor_spi_tx #(.CLK_DIV(1), .WORD_W(16)) u_div1 (
      .clk(clk), .reset_b(reset_b), .start(start[1]), .xcursor(xc[1]), .ycursor(yc[1]),
      .sclk(sclk[1]), .sdo(sdo[1]), .cs_b(cs_b[1]), .busy(busy[1]), .done(done[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Frame select is low from acceptance until the done cycle when enabled.
   function automatic logic cs_exp(input int t, input int total);
`ifdef CURSOR_SPI_CS_EN
      return (t >= total);
`else
      return 1'b1;
`endif
   endfunction

   // Caller has start asserted; the next rising edge is the acceptance edge E0.
   task automatic run_frame(input int sel, input int cd, input logic [15:0] x, input logic [15:0] y,
                            input bit hold, input bit change_x, input logic [15:0] new_x,
                            input string tag);
      int          total;
      int          edges;
      int          bad_ctl;
      int          bad_time;
      int          bad_stab;
      int          rise_t [32];
      logic        sdo_arr [0:264];
      logic [31:0] word;
      logic        prev;
      total    = 66 * cd;
      edges    = 0;
      bad_ctl  = 0;
      bad_time = 0;
      bad_stab = 0;
      word     = '0;
      @(posedge clk); #1;
      check({tag, ":e0_busy"}, 32'(busy[sel]), 32'd1);
      check({tag, ":e0_sdo"},  32'(sdo[sel]),  32'(x[15]));
      check({tag, ":e0_sclk"}, 32'(sclk[sel]), 32'd0);
      check({tag, ":e0_done"}, 32'(done[sel]), 32'd0);
      check({tag, ":e0_csb"},  32'(cs_b[sel]), 32'(cs_exp(0, total)));
      sdo_arr[0] = sdo[sel];
      prev       = sclk[sel];
      if (!hold) start[sel] = 1'b0;
      if (change_x) xc[sel] = new_x;
      for (int t = 1; t <= total; t++) begin
         @(posedge clk); #1;
         sdo_arr[t] = sdo[sel];
         if (!prev && sclk[sel]) begin
            if (edges < 32) begin
               rise_t[edges] = t;
               word = {word[30:0], sdo[sel]};
            end
            edges++;
         end
         prev = sclk[sel];
         if (busy[sel] !== (t < total)) bad_ctl++;
         if (done[sel] !== (t == total)) bad_ctl++;
         if (cs_b[sel] !== cs_exp(t, total)) bad_ctl++;
         if (t >= 65 * cd && t < total && sdo[sel] !== 1'b0) bad_ctl++;
      end
      check({tag, ":edges"}, 32'(edges), 32'd32);
      check({tag, ":word"},  word, {x, y});
      for (int k = 0; k < 32 && k < edges; k++) begin
         if (rise_t[k] != cd * (1 + 2 * k)) bad_time++;
         else begin
            for (int j = rise_t[k] - cd; j < rise_t[k] + cd; j++)
               if (sdo_arr[j] !== sdo_arr[rise_t[k]]) bad_stab++;
         end
      end
      check({tag, ":edge_times"}, 32'(bad_time), 32'd0);
      check({tag, ":sdo_stable"}, 32'(bad_stab), 32'd0);
      check({tag, ":ctl_profile"}, 32'(bad_ctl), 32'd0);
   endtask

   initial begin
      logic [15:0] rx, ry;
      int          seen_done;

      reset_b = 1'b0;
      start   = 2'b11;
      xc[0] = 16'h1111; yc[0] = 16'h2222;
      xc[1] = 16'h3333; yc[1] = 16'h4444;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check($sformatf("rst%0d:sclk", s), 32'(sclk[s]), 32'd0);
         check($sformatf("rst%0d:sdo", s),  32'(sdo[s]),  32'd0);
         check($sformatf("rst%0d:csb", s),  32'(cs_b[s]), 32'd1);
         check($sformatf("rst%0d:busy", s), 32'(busy[s]), 32'd0);
         check($sformatf("rst%0d:done", s), 32'(done[s]), 32'd0);
      end
      @(negedge clk);
      start   = 2'b00;
      reset_b = 1'b1;
      repeat (2) @(negedge clk);

      // Directed frame at the default divider.
      start[0] = 1'b1; xc[0] = 16'h0123; yc[0] = 16'h0456;
      run_frame(0, 4, 16'h0123, 16'h0456, 1'b0, 1'b0, 16'h0, "single");

      // Start held through the frame with x changed after capture; next frame follows done.
      @(negedge clk);
      start[0] = 1'b1; xc[0] = 16'hABCD; yc[0] = 16'h1357;
      run_frame(0, 4, 16'hABCD, 16'h1357, 1'b1, 1'b1, 16'h5A5A, "b2b_first");
      run_frame(0, 4, 16'h5A5A, 16'h1357, 1'b0, 1'b0, 16'h0, "b2b_second");

      // Asynchronous reset mid-frame.
      @(negedge clk);
      start[0] = 1'b1; xc[0] = 16'(($urandom)); yc[0] = 16'(($urandom));
      @(posedge clk); #1;
      start[0] = 1'b0;
      check("abort:busy_before", 32'(busy[0]), 32'd1);
      repeat (100) @(posedge clk);
      #2 reset_b = 1'b0;
      #1;
      check("abort:sclk", 32'(sclk[0]), 32'd0);
      check("abort:sdo",  32'(sdo[0]),  32'd0);
      check("abort:csb",  32'(cs_b[0]), 32'd1);
      check("abort:busy", 32'(busy[0]), 32'd0);
      seen_done = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done[0] !== 1'b0) seen_done++;
      end
      @(negedge clk);
      reset_b = 1'b1;
      repeat (300) begin
         @(posedge clk); #1;
         if (done[0] !== 1'b0 || busy[0] !== 1'b0) seen_done++;
      end
      check("abort:no_done", 32'(seen_done), 32'd0);
      @(negedge clk);
      rx = 16'($urandom); ry = 16'($urandom);
      start[0] = 1'b1; xc[0] = rx; yc[0] = ry;
      run_frame(0, 4, rx, ry, 1'b0, 1'b0, 16'h0, "after_abort");

      // Minimum divider.
      @(negedge clk);
      start[1] = 1'b1; xc[1] = 16'hFFFF; yc[1] = 16'h0000;
      run_frame(1, 1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0, "div1");

      // Random coordinates on both dividers.
      for (int i = 0; i < 3; i++) begin
         for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            rx = 16'($urandom); ry = 16'($urandom);
            start[s] = 1'b1; xc[s] = rx; yc[s] = ry;
            run_frame(s, (s == 0) ? 4 : 1, rx, ry, 1'b0, 1'b0, 16'h0,
                      $sformatf("rand%0d_%0d", s, i));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
